// File: rtl/io_timer.sv
// io_timer: memory-mapped down-counting timer with prescaler, auto-reload,
// sticky expiry/overrun status and a level interrupt.
module io_timer #(
    parameter logic [15:0] BASEADDR = 16'h0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dread_addr,
    output logic [15:0] dread_data,
    input  logic [15:0] dwrite_addr,
    input  logic [15:0] dwrite_data,
    input  logic [1:0]  dwrite_en,
    output logic        interrupt
);

    localparam int unsigned DW  = 16;
    localparam int unsigned PRW = 4;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_RELOAD = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    // Register state
    logic          r_en;
    logic          r_auto;
    logic          r_ie;
    logic [PRW-1:0] r_pre;
    logic [DW-1:0] r_reload;
    logic [DW-1:0] r_count;
    logic          r_exp;
    logic          r_ovr;
    logic [DW-1:0] r_ps;
    logic [DW-1:0] r_dread_data;

    // Decode and next-state wires
    logic [DW-1:0]  w_wr_off;
    logic [DW-1:0]  w_rd_off;
    logic           w_wr_hit;
    logic           w_rd_hit;
    logic           w_wr_ctrl;
    logic           w_wr_reload;
    logic           w_wr_count;
    logic           w_wr_status;
    logic [DW-1:0]  w_lane_mask;
    logic [DW-1:0]  w_ps_mask;
    logic           w_tick;
    logic           w_expire;
    logic           w_en_rise;
    logic [DW-1:0]  w_rd_data;

    logic           w_en_nxt;
    logic           w_auto_nxt;
    logic           w_ie_nxt;
    logic [PRW-1:0] w_pre_nxt;
    logic [DW-1:0]  w_reload_nxt;
    logic [DW-1:0]  w_count_nxt;
    logic           w_exp_nxt;
    logic           w_ovr_nxt;
    logic [DW-1:0]  w_ps_nxt;

    // Address decode; subtraction wraps so addresses below BASEADDR miss too
    assign w_wr_off    = dwrite_addr - BASEADDR;
    assign w_rd_off    = dread_addr - BASEADDR;
    assign w_wr_hit    = (dwrite_en != 2'b00) && (w_wr_off < DW'(8));
    assign w_rd_hit    = (w_rd_off < DW'(8));
    assign w_wr_ctrl   = w_wr_hit && (w_wr_off[2:1] == SEL_CTRL);
    assign w_wr_reload = w_wr_hit && (w_wr_off[2:1] == SEL_RELOAD);
    assign w_wr_count  = w_wr_hit && (w_wr_off[2:1] == SEL_COUNT);
    assign w_wr_status = w_wr_hit && (w_wr_off[2:1] == SEL_STATUS);
    assign w_lane_mask = {{8{dwrite_en[1]}}, {8{dwrite_en[0]}}};

    // Prescaler tick and expiry; a CPU write to COUNT suppresses expiry
    assign w_ps_mask = (DW'(1) << r_pre) - DW'(1);
    assign w_tick    = r_en && (r_ps == w_ps_mask);
    assign w_expire  = w_tick && (r_count == '0) && !w_wr_count;
    assign w_en_rise = w_wr_ctrl && dwrite_en[0] && dwrite_data[0] && !r_en;

    assign interrupt  = r_ie & r_exp;
    assign dread_data = r_dread_data;

    // Next-state for control, reload, count, status and prescaler
    always_comb begin
        w_en_nxt     = r_en;
        w_auto_nxt   = r_auto;
        w_ie_nxt     = r_ie;
        w_pre_nxt    = r_pre;
        w_reload_nxt = r_reload;
        w_count_nxt  = r_count;
        w_exp_nxt    = r_exp;
        w_ovr_nxt    = r_ovr;
        w_ps_nxt     = r_ps;

        // Prescaler runs only while enabled and restarts on each tick
        if (!r_en || w_tick || w_en_rise) begin
            w_ps_nxt = '0;
        end else begin
            w_ps_nxt = r_ps + DW'(1);
        end

        // Hardware count/expiry behaviour
        if (w_tick && !w_wr_count) begin
            if (r_count != '0) begin
                w_count_nxt = r_count - DW'(1);
            end else if (r_auto) begin
                w_count_nxt = r_reload;
            end else begin
                w_en_nxt = 1'b0;
            end
        end

        // CPU writes; later assignments give CPU priority over hardware
        if (w_wr_ctrl) begin
            if (dwrite_en[0]) begin
                w_en_nxt   = dwrite_data[0];
                w_auto_nxt = dwrite_data[1];
                w_ie_nxt   = dwrite_data[2];
            end
            if (dwrite_en[1]) begin
                w_pre_nxt = dwrite_data[11:8];
            end
        end
        if (w_wr_reload) begin
            w_reload_nxt = (r_reload & ~w_lane_mask) | (dwrite_data & w_lane_mask);
        end
        if (w_wr_count) begin
            w_count_nxt = (r_count & ~w_lane_mask) | (dwrite_data & w_lane_mask);
        end

        // Status: write-1-to-clear, hardware set takes priority
        if (w_wr_status && dwrite_en[0]) begin
            if (dwrite_data[0]) w_exp_nxt = 1'b0;
            if (dwrite_data[1]) w_ovr_nxt = 1'b0;
        end
        if (w_expire) begin
            w_exp_nxt = 1'b1;
            if (r_exp) w_ovr_nxt = 1'b1;
        end
    end

    // Read mux for the address presented this cycle
    always_comb begin
        w_rd_data = '0;
        if (w_rd_hit) begin
            case (w_rd_off[2:1])
                SEL_CTRL:   w_rd_data = {4'b0, r_pre, 5'b0, r_ie, r_auto, r_en};
                SEL_RELOAD: w_rd_data = r_reload;
                SEL_COUNT:  w_rd_data = r_count;
                SEL_STATUS: w_rd_data = {14'b0, r_ovr, r_exp};
                default:    w_rd_data = '0;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en         <= 1'b0;
            r_auto       <= 1'b0;
            r_ie         <= 1'b0;
            r_pre        <= '0;
            r_reload     <= '0;
            r_count      <= '0;
            r_exp        <= 1'b0;
            r_ovr        <= 1'b0;
            r_ps         <= '0;
            r_dread_data <= '0;
        end else begin
            r_en         <= w_en_nxt;
            r_auto       <= w_auto_nxt;
            r_ie         <= w_ie_nxt;
            r_pre        <= w_pre_nxt;
            r_reload     <= w_reload_nxt;
            r_count      <= w_count_nxt;
            r_exp        <= w_exp_nxt;
            r_ovr        <= w_ovr_nxt;
            r_ps         <= w_ps_nxt;
            r_dread_data <= w_rd_data;
        end
    end

endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: scenario tasks for io_timer with a read-data scoreboard queue.
module tb_io_timer;

    localparam logic [15:0] BASE     = 16'h0010;
    localparam logic [15:0] A_CTRL   = BASE;
    localparam logic [15:0] A_RELOAD = 16'(BASE + 16'd2);
    localparam logic [15:0] A_COUNT  = 16'(BASE + 16'd4);
    localparam logic [15:0] A_STATUS = 16'(BASE + 16'd6);
    localparam logic [15:0] A_OUT    = 16'(BASE + 16'd8);

    logic        clk;
    logic        reset;
    logic [15:0] dread_addr;
    logic [15:0] dread_data;
    logic [15:0] dwrite_addr;
    logic [15:0] dwrite_data;
    logic [1:0]  dwrite_en;
    logic        interrupt;

    int          n_cmp;
    int          n_err;
    logic [15:0] sb[$];
    logic [15:0] exp_v;

    io_timer #(.BASEADDR(BASE)) dut (
        .clk         (clk),
        .reset       (reset),
        .dread_addr  (dread_addr),
        .dread_data  (dread_data),
        .dwrite_addr (dwrite_addr),
        .dwrite_data (dwrite_data),
        .dwrite_en   (dwrite_en),
        .interrupt   (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One write cycle; the write lands on this posedge
    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] en);
        dwrite_addr = a;
        dwrite_data = d;
        dwrite_en   = en;
        @(posedge clk);
        #1;
        dwrite_en   = 2'b00;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Present a read address and queue the value it must return next cycle
    task automatic rd_issue(input logic [15:0] a, input logic [15:0] e);
        dread_addr = a;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        logic [15:0] addrs [4];
        addrs = '{A_CTRL, A_RELOAD, A_COUNT, A_STATUS};
        do_reset();
        foreach (addrs[i]) begin
            rd_issue(addrs[i], 16'h0000);
            exp_v = sb.pop_front();
            n_cmp++;
            if (dread_data !== exp_v) begin
                n_err++;
                $display("FAIL reset_read[%0d]: got %h expected %h", i, dread_data, exp_v);
            end
        end
        n_cmp++;
        if (interrupt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: got %b expected 0", interrupt);
        end
    endtask

    task automatic test_auto_reload();
        do_reset();
        wr(A_RELOAD, 16'd3, 2'b11);
        wr(A_COUNT, 16'd3, 2'b11);
        wr(A_CTRL, 16'h0007, 2'b11);
        for (int k = 1; k <= 4; k++) begin
            idle();
            n_cmp++;
            if (interrupt !== (k == 4)) begin
                n_err++;
                $display("FAIL auto_irq_cycle%0d: got %b expected %b", k, interrupt, (k == 4));
            end
        end
        rd_issue(A_COUNT, 16'd3);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL auto_reloaded_count: got %h expected %h", dread_data, exp_v);
        end
        rd_issue(A_STATUS, 16'h0001);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL auto_status1: got %h expected %h", dread_data, exp_v);
        end
        idle();
        idle();
        rd_issue(A_STATUS, 16'h0003);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL auto_status_ovr: got %h expected %h", dread_data, exp_v);
        end
        wr(A_CTRL, 16'h0000, 2'b11);
        wr(A_STATUS, 16'h0003, 2'b11);
        n_cmp++;
        if (interrupt !== 1'b0) begin
            n_err++;
            $display("FAIL auto_irq_cleared: got %b expected 0", interrupt);
        end
        rd_issue(A_STATUS, 16'h0000);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL auto_status_cleared: got %h expected %h", dread_data, exp_v);
        end
    endtask

    task automatic test_prescale();
        logic [15:0] e;
        do_reset();
        wr(A_COUNT, 16'd2, 2'b11);
        wr(A_CTRL, 16'h0201, 2'b11);
        for (int k = 1; k <= 11; k++) begin
            int j;
            j = k - 1;
            e = (j < 4) ? 16'd2 : ((j < 8) ? 16'd1 : 16'd0);
            rd_issue(A_COUNT, e);
            exp_v = sb.pop_front();
            n_cmp++;
            if (dread_data !== exp_v) begin
                n_err++;
                $display("FAIL prescale_count_c%0d: got %h expected %h", j, dread_data, exp_v);
            end
            n_cmp++;
            if (interrupt !== 1'b0) begin
                n_err++;
                $display("FAIL prescale_irq_c%0d: got %b expected 0", j, interrupt);
            end
        end
        rd_issue(A_STATUS, 16'h0000);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL prescale_status_c11: got %h expected %h", dread_data, exp_v);
        end
        rd_issue(A_STATUS, 16'h0001);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL prescale_status_c12: got %h expected %h", dread_data, exp_v);
        end
        rd_issue(A_CTRL, 16'h0200);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL prescale_ctrl_en_off: got %h expected %h", dread_data, exp_v);
        end
        n_cmp++;
        if (interrupt !== 1'b0) begin
            n_err++;
            $display("FAIL prescale_irq_end: got %b expected 0", interrupt);
        end
    endtask

    task automatic test_byte_lanes();
        do_reset();
        wr(A_RELOAD, 16'hABCD, 2'b01);
        wr(A_RELOAD, 16'h1234, 2'b10);
        rd_issue(A_RELOAD, 16'h12CD);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL lanes_reload: got %h expected %h", dread_data, exp_v);
        end
        rd_issue(16'(A_RELOAD + 16'd1), 16'h12CD);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL lanes_odd_addr: got %h expected %h", dread_data, exp_v);
        end
        wr(A_OUT, 16'hFFFF, 2'b11);
        wr(A_CTRL, 16'hFFFF, 2'b11);
        rd_issue(A_CTRL, 16'h0F07);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL lanes_ctrl_mask: got %h expected %h", dread_data, exp_v);
        end
        wr(A_CTRL, 16'h0000, 2'b11);
        rd_issue(A_RELOAD, 16'h12CD);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL lanes_out_of_range_write: got %h expected %h", dread_data, exp_v);
        end
    endtask

    task automatic test_w1c_race();
        do_reset();
        wr(A_RELOAD, 16'd5, 2'b11);
        wr(A_COUNT, 16'd1, 2'b11);
        wr(A_CTRL, 16'h0007, 2'b11);
        idle();
        wr(A_STATUS, 16'h0001, 2'b11);
        n_cmp++;
        if (interrupt !== 1'b1) begin
            n_err++;
            $display("FAIL w1c_set_wins: got %b expected 1", interrupt);
        end
        wr(A_STATUS, 16'h0001, 2'b11);
        n_cmp++;
        if (interrupt !== 1'b0) begin
            n_err++;
            $display("FAIL w1c_clears: got %b expected 0", interrupt);
        end
        wr(A_CTRL, 16'h0000, 2'b11);
        rd_issue(A_STATUS, 16'h0000);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL w1c_status: got %h expected %h", dread_data, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        // CPU COUNT write on an expiring tick wins
        do_reset();
        wr(A_RELOAD, 16'd5, 2'b11);
        wr(A_CTRL, 16'h0003, 2'b11);
        wr(A_COUNT, 16'd7, 2'b11);
        rd_issue(A_COUNT, 16'd7);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL race_count_write: got %h expected %h", dread_data, exp_v);
        end
        rd_issue(A_STATUS, 16'h0000);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL race_no_expiry: got %h expected %h", dread_data, exp_v);
        end
        // CPU EN write on an auto-disable tick wins
        do_reset();
        wr(A_CTRL, 16'h0001, 2'b11);
        wr(A_CTRL, 16'h0001, 2'b11);
        rd_issue(A_CTRL, 16'h0001);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL race_en_cpu_wins: got %h expected %h", dread_data, exp_v);
        end
        rd_issue(A_STATUS, 16'h0003);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL race_ovr: got %h expected %h", dread_data, exp_v);
        end
        rd_issue(A_CTRL, 16'h0000);
        exp_v = sb.pop_front();
        n_cmp++;
        if (dread_data !== exp_v) begin
            n_err++;
            $display("FAIL race_en_auto_off: got %h expected %h", dread_data, exp_v);
        end
    endtask

    task automatic test_reset_mid_count();
        logic [15:0] addrs [5];
        addrs = '{A_CTRL, A_RELOAD, A_COUNT, A_STATUS, A_OUT};
        do_reset();
        wr(A_RELOAD, 16'h0055, 2'b11);
        wr(A_COUNT, 16'd5, 2'b11);
        wr(A_CTRL, 16'h0005, 2'b11);
        idle();
        dread_addr = A_COUNT;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (dread_data !== 16'h0000) begin
            n_err++;
            $display("FAIL midreset_dread: got %h expected 0000", dread_data);
        end
        for (int k = 0; k < 8; k++) idle();
        foreach (addrs[i]) begin
            rd_issue(addrs[i], 16'h0000);
            exp_v = sb.pop_front();
            n_cmp++;
            if (dread_data !== exp_v) begin
                n_err++;
                $display("FAIL midreset_read[%0d]: got %h expected %h", i, dread_data, exp_v);
            end
        end
        n_cmp++;
        if (interrupt !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_irq: got %b expected 0", interrupt);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        dread_addr  = 16'h0000;
        dwrite_addr = 16'h0000;
        dwrite_data = 16'h0000;
        dwrite_en   = 2'b00;
        @(posedge clk);
        #1;
        test_reset();
        test_auto_reload();
        test_prescale();
        test_byte_lanes();
        test_w1c_race();
        test_back_to_back();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_timer.md
IO_TIMER -- requirements
Module: io_timer

Interface
REQ-001 Parameter BASEADDR, default 16'h0010, byte address of register 0; occupies BASEADDR..BASEADDR+7, I/O space below MEMADDRBASE.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dread_addr  input  16  CPU read byte address, sampled every posedge clk.
REQ-005 dread_data  output  16  registered read data for the address sampled at the previous posedge.
REQ-006 dwrite_addr  input  16  CPU write byte address.
REQ-007 dwrite_data  input  16  CPU write data.
REQ-008 dwrite_en  input  2  byte-lane write strobes: bit0 -> data[7:0], bit1 -> data[15:8]; system decode already gated to I/O space.
REQ-009 interrupt  output  1  level interrupt request to CPU.

Function
REQ-010 Register map (offset = addr - BASEADDR, addr[0] ignored): 0 CTRL, 2 RELOAD, 4 COUNT, 6 STATUS.
REQ-011 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE, bits[11:8] PRE (prescale exponent); other bits read 0, writes ignored.
REQ-012 RELOAD: 16-bit read/write reload value.
REQ-013 COUNT: read returns current count; write loads count directly.
REQ-014 STATUS: bit0 EXP, bit1 OVR; write-1-to-clear per bit, write-0 no effect; other bits read 0.
REQ-015 Write takes effect at the posedge where dwrite_en != 0 and address decodes; only enabled byte lanes update.
REQ-016 Read latency one cycle: dread_data at posedge N+1 reflects register state before the posedge-N+1 update for dread_addr held at N; out-of-range address -> 16'h0000.
REQ-017 Prescaler: 16-bit counter PS, increments each cycle while EN=1; tick when PS == 2^PRE - 1, then PS <= 0; PRE=0 -> tick every cycle.
REQ-018 PS cleared whenever EN=0 and on any write to CTRL that sets EN from 0 to 1.
REQ-019 On tick with COUNT != 0: COUNT <= COUNT - 1.
REQ-020 On tick with COUNT == 0: EXP <= 1; if EXP already 1, OVR <= 1; if AUTO=1, COUNT <= RELOAD, else EN <= 0 and COUNT stays 0.
REQ-021 Expiry is detected at COUNT==0 on a tick, so period = (RELOAD+1) ticks in auto mode.
REQ-022 Simultaneous CPU write to COUNT and tick: CPU value wins, no decrement, no expiry that cycle.
REQ-023 Simultaneous W1C of EXP/OVR and hardware set of same bit: set wins (bit stays 1).
REQ-024 Simultaneous CPU write to CTRL.EN and hardware auto-disable: CPU value wins.
REQ-025 COUNT decrement never wraps below 0; no event occurs when EN=0.
REQ-026 interrupt = IE & EXP, combinational from registers, no added latency.

Reset
REQ-027 reset=1 at posedge: CTRL, RELOAD, COUNT, STATUS, PS, dread_data all <= 0; interrupt therefore 0.
REQ-028 Reset overrides any simultaneous write or tick; reset mid-count aborts with no EXP set.
REQ-029 Register reads are valid starting one cycle after reset deasserts.

Verification
REQ-030 Reset then read offsets 0,2,4,6 -> 16'h0000 each, interrupt=0.
REQ-031 RELOAD=3, COUNT=3, CTRL=16'h0007 (PRE=0) -> EXP=1 and interrupt=1 exactly 4 cycles after EN write; COUNT reloads to 3; second expiry 4 cycles later sets OVR=1.
REQ-032 COUNT=2, CTRL=16'h0201 (PRE=2, no AUTO, no IE) -> COUNT decrements every 4 cycles, EXP=1 after 12 cycles, EN reads 0, interrupt stays 0.
REQ-033 Byte lanes: write 16'hABCD to RELOAD with dwrite_en=2'b01 then 16'h1234 with 2'b10 -> RELOAD reads 16'h12CD.
REQ-034 Write STATUS=16'h0001 on same cycle as expiry -> EXP remains 1; next-cycle W1C clears EXP, interrupt falls to 0 in that cycle.
REQ-035 Assert reset while COUNT=5 counting -> all registers 0, no EXP, interrupt 0; read of BASEADDR+8 returns 16'h0000.
